// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 serial receiver with a valid/ready byte output.
// The raw line is double-flopped, start bits are confirmed at mid-bit, data
// bits are sampled LSB first at mid-bit, and each good frame is offered to the
// downstream buffer through a single holding register.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  // Reject parameter values the bit timing cannot support.
  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx: CLKS_PER_BIT must be 4 or more");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bits_check
    $error("uart_rx: DATA_BITS must be in 5..8");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic                 sync1_q, sync2_q;
  logic                 rx_s;

  assign rx_s = sync2_q;

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, counters, shift register and output holding register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // A completed transfer empties the holding register unless a load
    // below overrides it on the same cycle.
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (!rx_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          if (rx_s) begin
            // Line went back high before mid-bit: treat as a glitch.
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = {CNT_W{1'b0}};
            idx_d   = {IDX_W{1'b0}};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          // Shift in from the top so the first bit ends up in bit 0.
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = {CNT_W{1'b0}};
          if (idx_q == IDX_LAST) begin
            idx_d   = {IDX_W{1'b0}};
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          if (rx_s) begin
            if (!valid_q || out_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_IDLE: begin
        // Hold off until the line returns high so a break reports once.
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        idx_d   = {IDX_W{1'b0}};
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      shift_q <= {DATA_BITS{1'b0}};
      data_q  <= {DATA_BITS{1'b0}};
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  int n_vec  = 0;
  int n_miss = 0;

  int cyc      = 0;
  int fall_cyc = 0;
  int lat      = 0;
  int xfer_cnt = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int vhi_cnt  = 0;
  int stab_err = 0;
  logic [7:0] xdata [0:31];
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: transfers, pulses, latency and hold stability.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (xfer_cnt < 32) xdata[xfer_cnt] = out_data;
      xfer_cnt = xfer_cnt + 1;
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (overrun)   ovr_cnt  = ovr_cnt + 1;
    if (out_valid) vhi_cnt  = vhi_cnt + 1;
    if (out_valid && !prev_valid) lat = cyc - fall_cyc;
    if (prev_valid && !prev_ready && out_valid && (out_data != prev_data))
      stab_err = stab_err + 1;
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_data  = out_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int x0, f0, o0, v0;

  initial begin
    rst       = 1'b1;
    rx        = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data",  out_data,  0);
    check_eq("rst_ferr",  frame_err, 0);
    check_eq("rst_ovr",   overrun,   0);
    check_eq("rst_busy",  busy,      0);
    rst = 1'b0;
    idle(5);

    // Single good frame with ready held high.
    x0 = xfer_cnt; f0 = ferr_cnt; o0 = ovr_cnt; v0 = vhi_cnt;
    send_frame(8'h55, 1'b1);
    idle(20);
    check_eq("t1_xfers",  xfer_cnt - x0, 1);
    check_eq("t1_data",   xdata[x0], 8'h55);
    check_eq("t1_vwidth", vhi_cnt - v0, 1);
    check_eq("t1_ferr",   ferr_cnt - f0, 0);
    check_eq("t1_ovr",    ovr_cnt - o0, 0);
    check_eq("t1_lat",    lat, 155);

    // Short low glitch is rejected as a false start.
    x0 = xfer_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("t2_busy_hi", busy, 1);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("t2_busy_lo", busy, 0);
    check_eq("t2_valid",   out_valid, 0);
    check_eq("t2_ferr",    ferr_cnt - f0, 0);
    check_eq("t2_xfers",   xfer_cnt - x0, 0);

    // Bad stop bit followed by a held-low line.
    x0 = xfer_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check_eq("t3_busy_hi", busy, 1);
    idle(6);
    check_eq("t3_busy_lo", busy, 0);
    check_eq("t3_ferr",    ferr_cnt - f0, 1);
    check_eq("t3_xfers",   xfer_cnt - x0, 0);
    check_eq("t3_valid",   out_valid, 0);
    idle(10);

    // Holding register full: second byte is dropped.
    x0 = xfer_cnt; o0 = ovr_cnt;
    out_ready = 1'b0;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(20);
    check_eq("t4_valid_hold", out_valid, 1);
    check_eq("t4_data_hold",  out_data, 8'hA5);
    check_eq("t4_ovr",        ovr_cnt - o0, 1);
    check_eq("t4_no_xfer",    xfer_cnt - x0, 0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t4_xfers",     xfer_cnt - x0, 1);
    check_eq("t4_xdata",     xdata[x0], 8'hA5);
    check_eq("t4_valid_off", out_valid, 0);

    // Back-to-back frames with no idle gap.
    x0 = xfer_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    check_eq("t5_xfers", xfer_cnt - x0, 2);
    check_eq("t5_first", xdata[x0], 8'h00);
    check_eq("t5_second", xdata[x0 + 1], 8'hFF);
    check_eq("t5_ferr",  ferr_cnt - f0, 0);
    check_eq("t5_ovr",   ovr_cnt - o0, 0);

    // Reset in the middle of bit 3 of 0x81, then a clean 0x7E.
    x0 = xfer_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t6_rst_busy",  busy, 0);
    check_eq("t6_rst_valid", out_valid, 0);
    check_eq("t6_rst_data",  out_data, 0);
    check_eq("t6_rst_ferr",  frame_err, 0);
    check_eq("t6_rst_ovr",   overrun, 0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(30);
    send_frame(8'h7E, 1'b1);
    idle(20);
    check_eq("t6_xfers", xfer_cnt - x0, 1);
    check_eq("t6_data",  xdata[x0], 8'h7E);
    check_eq("t6_busy",  busy, 0);

    check_eq("hold_stable", stab_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
